mdu_ctrl: RTL and testbench



---
 rtl/mdu_pkg.sv | 24 ++
 rtl/mdu_ctrl_if.sv | 33 +++
 rtl/mdu_div_core.sv | 50 +++++
 rtl/mdu_ctrl.sv | 148 ++++++++++++++
 tb/tb_mdu_ctrl.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types and constants for the HI/LO multiply/divide unit.
// Holds the sequencer state enum, request bit indices and counter sizing.
package mdu_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MUL     = 2'd1,
        S_DIV_RUN = 2'd2,
        S_DIV_FIX = 2'd3
    } mdu_state_e;

    localparam int MD_MUL    = 0;
    localparam int MD_DIV    = 1;
    localparam int MD_SIGNED = 2;
    localparam int MT_LO     = 0;
    localparam int MT_HI     = 1;

    localparam int DIV_CNT_W = $clog2(32);

    function automatic int div_cnt_w(input int w);
        return $clog2(w);
    endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// mdu_ctrl_if: EX -> MDU request bundle with valid/ready handshake.
// master = EX side (drives request), slave = MDU side (drives req_ready).
interface mdu_ctrl_if #(
    parameter int DATA_W = 32
);
    import mdu_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [2:0]        mul_div;
    logic [1:0]        mt_hi_lo;
    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] src_b;

    modport master (
        output req_valid,
        output mul_div,
        output mt_hi_lo,
        output src_a,
        output src_b,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  mul_div,
        input  mt_hi_lo,
        input  src_a,
        input  src_b,
        output req_ready
    );

endinterface

// File: rtl/mdu_div_core.sv
// mdu_div_core: restoring-divide datapath, one quotient bit per step.
// Ports: clk, rst_n, load (capture operands), step (one iteration),
// dividend/divisor magnitudes in, quo/rem magnitudes out.
module mdu_div_core
    import mdu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] quo,
    output logic [DATA_W-1:0] rem
);

    logic [DATA_W-1:0] dvs;
    logic [DATA_W:0]   shifted;
    logic [DATA_W:0]   diff;

    // Quotient register doubles as the dividend shifter: its MSB
    // feeds the partial remainder, the new quotient bit enters at LSB.
    always_comb begin
        shifted = {rem, quo[DATA_W-1]};
        diff    = shifted - {1'b0, dvs};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quo <= '0;
            rem <= '0;
            dvs <= '0;
        end else if (load) begin
            quo <= dividend;
            rem <= '0;
            dvs <= divisor;
        end else if (step) begin
            if (!diff[DATA_W]) begin
                rem <= diff[DATA_W-1:0];
                quo <= {quo[DATA_W-2:0], 1'b1};
            end else begin
                rem <= shifted[DATA_W-1:0];
                quo <= {quo[DATA_W-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: HI/LO owner and mult/div sequencer beside the EX stage.
// Ports: clk, rst_n, req (slave request bundle), flush, busy, done, hi, lo.
// Build option MDU_DIV_ZERO_FAST_EN: zero divisor skips the iterations.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    mdu_ctrl_if.slave         req,
    input  logic              flush,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int CNT_W = div_cnt_w(DATA_W);

`ifdef MDU_DIV_ZERO_FAST_EN
    localparam bit FAST_ZERO = 1'b1;
`else
    localparam bit FAST_ZERO = 1'b0;
`endif

    mdu_state_e        state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              op_sgn;
    logic              q_neg;
    logic              r_neg;
    logic              zfast;

    logic              acc;
    logic              is_div;
    logic              is_mul;
    logic              sgn;
    logic              a_neg;
    logic              b_neg;
    logic              b_zero;
    logic [DATA_W-1:0] a_mag;
    logic [DATA_W-1:0] b_mag;
    logic [DATA_W-1:0] quo;
    logic [DATA_W-1:0] rem;
    logic [2*DATA_W+1:0] prod_full;

    assign req.req_ready = (state == S_IDLE);
    assign busy = (state != S_IDLE);
    assign done = ((state == S_MUL) || (state == S_DIV_FIX)) && !flush;

    assign acc    = req.req_valid && req.req_ready && !flush;
    assign is_div = req.mul_div[MD_DIV];
    assign is_mul = req.mul_div[MD_MUL] && !is_div;
    assign sgn    = req.mul_div[MD_SIGNED];
    assign a_neg  = sgn && req.src_a[DATA_W-1];
    assign b_neg  = sgn && req.src_b[DATA_W-1];
    assign b_zero = (req.src_b == '0);
    assign a_mag  = a_neg ? -req.src_a : req.src_a;
    assign b_mag  = b_neg ? -req.src_b : req.src_b;

    // One extra sign bit per operand lets a single signed multiply
    // serve both mult and multu.
    assign prod_full =
        $signed({op_sgn && op_a[DATA_W-1], op_a}) *
        $signed({op_sgn && op_b[DATA_W-1], op_b});

    mdu_div_core #(
        .DATA_W (DATA_W)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (acc && is_div),
        .step     ((state == S_DIV_RUN) && !flush),
        .dividend (a_mag),
        .divisor  (b_mag),
        .quo      (quo),
        .rem      (rem)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            op_a   <= '0;
            op_b   <= '0;
            op_sgn <= 1'b0;
            q_neg  <= 1'b0;
            r_neg  <= 1'b0;
            zfast  <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (acc) begin
                        if (is_div) begin
                            op_a  <= req.src_a;
                            q_neg <= a_neg ^ b_neg;
                            r_neg <= a_neg;
                            cnt   <= '0;
                            zfast <= FAST_ZERO && b_zero;
                            state <= (FAST_ZERO && b_zero) ?
                                     S_DIV_FIX : S_DIV_RUN;
                        end else if (is_mul) begin
                            op_a   <= req.src_a;
                            op_b   <= req.src_b;
                            op_sgn <= sgn;
                            state  <= S_MUL;
                        end else begin
                            if (req.mt_hi_lo[MT_HI]) hi <= req.src_a;
                            if (req.mt_hi_lo[MT_LO]) lo <= req.src_a;
                        end
                    end
                end
                S_MUL: begin
                    if (!flush) begin
                        {hi, lo} <= prod_full[2*DATA_W-1:0];
                    end
                    state <= S_IDLE;
                end
                S_DIV_RUN: begin
                    cnt <= cnt + 1'b1;
                    if (flush) begin
                        state <= S_IDLE;
                    end else if (cnt == CNT_W'(DATA_W-1)) begin
                        state <= S_DIV_FIX;
                    end
                end
                S_DIV_FIX: begin
                    if (!flush) begin
                        if (zfast) begin
                            lo <= '1;
                            hi <= op_a;
                        end else begin
                            lo <= q_neg ? -quo : quo;
                            hi <= r_neg ? -rem : rem;
                        end
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed vectors for mdu_ctrl with a done-driven scoreboard.
// Expected HI/LO and write edge are queued at accept and checked at done.
module tb_mdu_ctrl;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_acc = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          due;
    } exp_t;

    exp_t sb[$];

    mdu_ctrl_if #(.DATA_W(32)) bus ();

    mdu_ctrl #(
        .DATA_W (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (bus),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Presents one request, holds it until accepted, then drops valid.
    task automatic issue(input logic [2:0] md, input logic [1:0] mt,
                         input logic [31:0] a, input logic [31:0] b,
                         input bit push, input logic [31:0] ehi,
                         input logic [31:0] elo, input int lat);
        int n;
        exp_t e;
        bus.mul_div   = md;
        bus.mt_hi_lo  = mt;
        bus.src_a     = a;
        bus.src_b     = b;
        bus.req_valid = 1'b1;
        n = 0;
        while (!bus.req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            chk("accept_timeout", 64'(n), 64'd0);
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        last_acc = cyc;
        if (push) begin
            e.hi  = ehi;
            e.lo  = elo;
            e.due = cyc + lat;
            sb.push_back(e);
        end else if (md[1:0] == 2'b00 && mt != 2'b00) begin
            chk("mt_hi", 64'(hi), 64'(ehi));
            chk("mt_lo", 64'(lo), 64'(elo));
            chk("mt_busy", 64'(busy), 64'd0);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued result.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("done_edge", 64'(cyc + 1), 64'(e.due));
                    @(posedge clk);
                    #1;
                    chk("res_hi", 64'(hi), 64'(e.hi));
                    chk("res_lo", 64'(lo), 64'(e.lo));
                end
            end
        end
    end

    initial begin
        int n;
        int div_acc;
        bus.req_valid = 1'b0;
        bus.mul_div   = 3'b000;
        bus.mt_hi_lo  = 2'b00;
        bus.src_a     = '0;
        bus.src_b     = '0;

        repeat (3) @(negedge clk);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_ready", 64'(bus.req_ready), 64'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // signed mult -2 * 3
        issue(3'b101, 2'b00, 32'hFFFF_FFFE, 32'd3, 1'b1,
              32'hFFFF_FFFF, 32'hFFFF_FFFA, 1);
        chk("mul_busy_e0", 64'(busy), 64'd1);
        @(posedge clk);
        #1;
        chk("mul_busy_e1", 64'(busy), 64'd0);

        // unsigned div 100 / 7, ready low for the full 33 cycles
        issue(3'b010, 2'b00, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14, 33);
        n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("divu_ready_low", 64'(n), 64'd33);

        // mult+div both set and mt bits set: div wins, mt ignored
        issue(3'b011, 2'b11, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14, 33);

        // signed -7 / 2, then mtlo held while busy
        issue(3'b110, 2'b00, 32'hFFFF_FFF9, 32'd2, 1'b1,
              32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
        div_acc = last_acc;
        issue(3'b000, 2'b01, 32'h0000_ABCD, 32'd0, 1'b0,
              32'hFFFF_FFFF, 32'h0000_ABCD, 0);
        chk("held_req_edge", 64'(last_acc - div_acc), 64'd34);

        // signed overflow 0x80000000 / -1
        issue(3'b110, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1,
              32'h0, 32'h8000_0000, 33);

        // mthi+mtlo together, then separate preload
        issue(3'b000, 2'b11, 32'h0000_9999, 32'd0, 1'b0,
              32'h0000_9999, 32'h0000_9999, 0);
        issue(3'b000, 2'b10, 32'h0000_1234, 32'd0, 1'b0,
              32'h0000_1234, 32'h0000_9999, 0);
        issue(3'b000, 2'b01, 32'h0000_5678, 32'd0, 1'b0,
              32'h0000_1234, 32'h0000_5678, 0);

        // flush a divide at iteration 10
        issue(3'b010, 2'b00, 32'd100, 32'd7, 1'b0, 32'd0, 32'd0, 0);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_div_busy", 64'(busy), 64'd0);
        chk("flush_div_hi", 64'(hi), 64'h1234);
        chk("flush_div_lo", 64'(lo), 64'h5678);
        repeat (40) @(negedge clk);
        chk("flush_div_hi_late", 64'(hi), 64'h1234);
        chk("flush_div_lo_late", 64'(lo), 64'h5678);

        // flush a multiply in its only cycle
        issue(3'b001, 2'b00, 32'd5, 32'd6, 1'b0, 32'd0, 32'd0, 0);
        flush = 1'b1;
        #1;
        chk("flush_mul_done", 64'(done), 64'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_mul_busy", 64'(busy), 64'd0);
        chk("flush_mul_lo", 64'(lo), 64'h5678);

        // signed -5 / 0
`ifdef MDU_DIV_ZERO_FAST_EN
        issue(3'b110, 2'b00, 32'hFFFF_FFFB, 32'd0, 1'b1,
              32'hFFFF_FFFB, 32'hFFFF_FFFF, 1);
`else
        issue(3'b110, 2'b00, 32'hFFFF_FFFB, 32'd0, 1'b1,
              32'hFFFF_FFFB, 32'h0000_0001, 33);
`endif
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);

        // async reset in the middle of a divide
        issue(3'b010, 2'b00, 32'd100, 32'd7, 1'b0, 32'd0, 32'd0, 0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_hi", 64'(hi), 64'd0);
        chk("midrst_lo", 64'(lo), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_ready", 64'(bus.req_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
